conv_frame_ctrl: RTL and testbench

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_frame_ctrl_if.sv | 29 ++
 rtl/conv_pix_counter.sv | 41 ++++
 rtl/conv_frame_ctrl.sv | 136 +++++++++++++
 tb/tb_conv_frame_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution frame controller.
package conv_pkg;

  localparam int COORD_W      = 10;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int PIPE_LAT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    FLUSH    = 2'd3
  } state_t;

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// Camera-side inputs and datapath-side outputs of the frame controller.
// master = camera/stimulus side, slave = conv_frame_ctrl.
interface conv_frame_ctrl_if;
  import conv_pkg::*;

  logic               iEN;
  logic               iFVAL;
  logic               iDVAL;
  logic               iSEL;
  logic               oCONV_EN;
  logic               oF_SELECT;
  logic [COORD_W-1:0] oX;
  logic [COORD_W-1:0] oY;
  logic               oBORDER;
  logic               oFRAME_DONE;
  logic               oFRAME_ERR;
  logic [15:0]        oFRAME_CNT;

  modport master (
    output iEN, iFVAL, iDVAL, iSEL,
    input  oCONV_EN, oF_SELECT, oX, oY, oBORDER, oFRAME_DONE, oFRAME_ERR, oFRAME_CNT
  );

  modport slave (
    input  iEN, iFVAL, iDVAL, iSEL,
    output oCONV_EN, oF_SELECT, oX, oY, oBORDER, oFRAME_DONE, oFRAME_ERR, oFRAME_CNT
  );

endinterface

// File: rtl/conv_pix_counter.sv
// Raster X/Y counter for accepted pixels; overrun flags a fully counted frame.
module conv_pix_counter
  import conv_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               i_clear,
  input  logic               i_step,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_overrun
);

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_step) begin
      if (r_x == COORD_W'(H_ACTIVE - 1)) begin
        r_x <= '0;
        r_y <= r_y + COORD_W'(1);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_overrun = (r_y >= COORD_W'(V_ACTIVE));

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame controller: tracks camera FVAL/DVAL, drives the convolution strobe and counts frames.
// Define CONV_CTRL_BORDER_EN to build the border-flag pipe; otherwise oBORDER is tied low.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  conv_frame_ctrl_if.slave  bus
);

  localparam int FLUSH_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t               r_state;
  logic                 r_fvalPrev;
  logic [FLUSH_W-1:0]   r_flushCnt;
  logic                 r_fSelect;
  logic                 r_done;
  logic                 r_err;
  logic [15:0]          r_frameCnt;

  logic [COORD_W-1:0]   w_x;
  logic [COORD_W-1:0]   w_y;
  logic                 w_overrun;
  logic                 w_sof;
  logic                 w_eof;
  logic                 w_convEn;
  logic                 w_clear;
  logic                 w_lastPix;
  logic                 w_frameFull;

  assign w_sof    = bus.iFVAL & ~r_fvalPrev;
  assign w_eof    = ~bus.iFVAL & r_fvalPrev;
  assign w_convEn = bus.iDVAL & (r_state == ACTIVE) & ~w_overrun;
  assign w_clear  = (r_state == WAIT_SOF) & bus.iEN & w_sof;

  // A frame ending on the very cycle of its last pixel is still complete.
  assign w_lastPix   = w_convEn & (w_x == COORD_W'(H_ACTIVE - 1)) & (w_y == COORD_W'(V_ACTIVE - 1));
  assign w_frameFull = w_overrun | w_lastPix;

  conv_pix_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pixCounter (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .i_clear   (w_clear),
    .i_step    (w_convEn),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_overrun (w_overrun)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state    <= IDLE;
      r_fvalPrev <= 1'b0;
      r_flushCnt <= '0;
      r_fSelect  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_frameCnt <= '0;
    end else begin
      r_fvalPrev <= bus.iFVAL;
      r_done     <= 1'b0;
      if (!bus.iEN) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: r_state <= WAIT_SOF;
          WAIT_SOF: begin
            if (w_sof) begin
              r_state   <= ACTIVE;
              r_fSelect <= bus.iSEL;
            end
          end
          ACTIVE: begin
            if (bus.iDVAL && w_overrun) r_err <= 1'b1;
            if (w_eof) begin
              r_state    <= FLUSH;
              r_flushCnt <= '0;
              if (!w_frameFull) r_err <= 1'b1;
            end
          end
          FLUSH: begin
            // FVAL edges seen here are deliberately lost; that frame is skipped.
            if (r_flushCnt == FLUSH_W'(PIPE_LAT - 1)) begin
              r_done     <= 1'b1;
              r_frameCnt <= r_frameCnt + 16'd1;
              r_state    <= WAIT_SOF;
            end else begin
              r_flushCnt <= r_flushCnt + FLUSH_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
      if (w_clear) r_err <= 1'b0;
    end
  end

`ifdef CONV_CTRL_BORDER_EN
  logic [PIPE_LAT-1:0] r_borderPipe;
  logic                w_borderPix;

  assign w_borderPix = w_convEn & ((w_x < COORD_W'(2)) | (w_y < COORD_W'(2)));

  // Fixed-latency shift so the flag lines up with the datapath's output valid.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_borderPipe <= '0;
    end else begin
      r_borderPipe[0] <= w_borderPix;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_borderPipe[i] <= r_borderPipe[i-1];
      end
    end
  end

  assign bus.oBORDER = r_borderPipe[PIPE_LAT-1];
`else
  assign bus.oBORDER = 1'b0;
`endif

  assign bus.oCONV_EN    = w_convEn;
  assign bus.oF_SELECT   = r_fSelect;
  assign bus.oX          = w_x;
  assign bus.oY          = w_y;
  assign bus.oFRAME_DONE = r_done;
  assign bus.oFRAME_ERR  = r_err;
  assign bus.oFRAME_CNT  = r_frameCnt;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl at H=4, V=3, PIPE_LAT=3.
// Border expectations follow CONV_CTRL_BORDER_EN.
module tb_conv_frame_ctrl;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int PL = 3;

  // Pixels 0..9 of a raster 4x3 frame are border pixels; they surface at stimulus calls 3..12.
`ifdef CONV_CTRL_BORDER_EN
  localparam logic [31:0] BORDER_EXP = 32'h0000_1FF8;
`else
  localparam logic [31:0] BORDER_EXP = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rstN;

  always #5 clk = ~clk;

  conv_frame_ctrl_if bus ();

  conv_frame_ctrl #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .PIPE_LAT (PL)
  ) dut (
    .iCLK (clk),
    .iRST (rstN),
    .bus  (bus)
  );

  int          checkCount = 0;
  int          failCount  = 0;
  int          convPulses;
  int          donePulses;
  int          doneLat;
  int          traceIdx;
  logic [31:0] borderTrace;
  logic        errAfterSof;
  logic        selAfterSof;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got=%0d want=%0d", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; the combinational strobe is sampled before the edge, registers after it.
  task automatic applyStimulus(input logic fval, input logic dval);
    bus.iFVAL = fval;
    bus.iDVAL = dval;
    #1;
    if (bus.oCONV_EN === 1'b1) convPulses++;
    @(posedge clk);
    #1;
    if (bus.oFRAME_DONE === 1'b1) donePulses++;
    if (traceIdx < 32) begin
      borderTrace[traceIdx] = bus.oBORDER;
      traceIdx++;
    end
  endtask

  task automatic sendFrame(input int pixels, input logic selSof, input logic selMid);
    convPulses  = 0;
    donePulses  = 0;
    doneLat     = 0;
    traceIdx    = 0;
    borderTrace = '0;
    bus.iSEL    = selSof;
    applyStimulus(1'b1, 1'b0);
    errAfterSof = bus.oFRAME_ERR;
    selAfterSof = bus.oF_SELECT;
    for (int p = 0; p < pixels; p++) begin
      if (p == 5) bus.iSEL = selMid;
      applyStimulus(1'b1, 1'b1);
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int n = 1; n <= 10 && doneLat == 0; n++) begin
      applyStimulus(1'b0, 1'b0);
      if (bus.oFRAME_DONE === 1'b1) doneLat = n;
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic checkFrame(input string name, input int expConv, input int expX, input int expY,
                            input int expCnt, input int expErr, input int expSel,
                            input int expErrSof, input int expSelSof);
    checkOutput($sformatf("%s.conv", name),    convPulses,     expConv);
    checkOutput($sformatf("%s.x", name),       bus.oX,         expX);
    checkOutput($sformatf("%s.y", name),       bus.oY,         expY);
    checkOutput($sformatf("%s.cnt", name),     bus.oFRAME_CNT, expCnt);
    checkOutput($sformatf("%s.err", name),     bus.oFRAME_ERR, expErr);
    checkOutput($sformatf("%s.sel", name),     bus.oF_SELECT,  expSel);
    checkOutput($sformatf("%s.doneLat", name), doneLat,        3);
    checkOutput($sformatf("%s.donePul", name), donePulses,     1);
    checkOutput($sformatf("%s.errSof", name),  errAfterSof,    expErrSof);
    checkOutput($sformatf("%s.selSof", name),  selAfterSof,    expSelSof);
  endtask

  initial begin
    bus.iEN   = 1'b0;
    bus.iFVAL = 1'b0;
    bus.iDVAL = 1'b1;
    bus.iSEL  = 1'b0;
    rstN      = 1'b0;
    traceIdx  = 32;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.convEn", bus.oCONV_EN,    0);
    checkOutput("rst.x",      bus.oX,          0);
    checkOutput("rst.y",      bus.oY,          0);
    checkOutput("rst.sel",    bus.oF_SELECT,   0);
    checkOutput("rst.border", bus.oBORDER,     0);
    checkOutput("rst.done",   bus.oFRAME_DONE, 0);
    checkOutput("rst.err",    bus.oFRAME_ERR,  0);
    checkOutput("rst.cnt",    bus.oFRAME_CNT,  0);

    bus.iDVAL = 1'b0;
    rstN      = 1'b1;
    bus.iEN   = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    sendFrame(12, 1'b0, 1'b0);
    checkFrame("full1", 12, 0, 3, 1, 0, 0, 0, 0);
    checkOutput("full1.border", borderTrace, BORDER_EXP);

    sendFrame(12, 1'b1, 1'b0);
    checkFrame("selHold", 12, 0, 3, 2, 0, 1, 0, 1);

    sendFrame(10, 1'b0, 1'b1);
    checkFrame("short", 10, 2, 2, 3, 1, 0, 0, 0);

    sendFrame(14, 1'b1, 1'b1);
    checkFrame("overrun", 12, 0, 3, 4, 1, 1, 0, 1);
    checkOutput("overrun.border", borderTrace, BORDER_EXP);

    // Enable dropped mid-frame: no done pulse and no count.
    convPulses = 0;
    donePulses = 0;
    traceIdx   = 32;
    bus.iSEL   = 1'b0;
    applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1);
    bus.iEN = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, 1'b0);
    checkOutput("abort.conv",    convPulses,     4);
    checkOutput("abort.donePul", donePulses,     0);
    checkOutput("abort.cnt",     bus.oFRAME_CNT, 4);
    bus.iEN = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0);

    // Reset asserted after five pixels, with FVAL still high through release.
    bus.iSEL = 1'b1;
    applyStimulus(1'b1, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b1);
    bus.iDVAL = 1'b0;
    checkOutput("preRst.x",   bus.oX,        1);
    checkOutput("preRst.y",   bus.oY,        1);
    checkOutput("preRst.sel", bus.oF_SELECT, 1);
    rstN = 1'b0;
    #1;
    checkOutput("midRst.x",      bus.oX,          0);
    checkOutput("midRst.y",      bus.oY,          0);
    checkOutput("midRst.sel",    bus.oF_SELECT,   0);
    checkOutput("midRst.border", bus.oBORDER,     0);
    checkOutput("midRst.done",   bus.oFRAME_DONE, 0);
    checkOutput("midRst.err",    bus.oFRAME_ERR,  0);
    checkOutput("midRst.cnt",    bus.oFRAME_CNT,  0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0);
    sendFrame(12, 1'b0, 1'b0);
    checkFrame("postRst", 12, 0, 3, 1, 0, 0, 0, 0);

    // FVAL rises while flushing: that frame is skipped entirely.
    donePulses = 0;
    traceIdx   = 32;
    applyStimulus(1'b1, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    convPulses = 0;
    repeat (12) applyStimulus(1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, 1'b0);
    checkOutput("skip.conv",    convPulses,     0);
    checkOutput("skip.donePul", donePulses,     1);
    checkOutput("skip.cnt",     bus.oFRAME_CNT, 2);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
